imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
- Shares the single-port, byte-addressed, little-endian 32-bit instruction memory between two requesters: the IF-stage fetch port and the boot/debug loader port.
- Sequences each access through a fixed-latency memory, returns data to the owning requester, and handles fetch flushes on branch.
- Sits between the IF stage and the instruction memory; the loader uses the same path to preload or inspect program words.

Parameters:
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal range 1..15).
- DEPTH_BYTES, 192, memory size in bytes; any address >= DEPTH_BYTES is out of range.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  fetch request, level-held until fetch_gnt.
- fetch_addr  in  ADDR_W  fetch byte address (PC).
- fetch_flush  in  1  discard any outstanding fetch (branch taken).
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted.
- fetch_rvalid  out  1  one-cycle pulse: fetch_rdata valid.
- fetch_rdata  out  32  instruction word.
- ld_req  in  1  loader request, level-held until ld_gnt.
- ld_we  in  1  loader write (1) or read (0).
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  32  loader write word.
- ld_gnt  out  1  one-cycle pulse: loader request accepted.
- ld_rvalid  out  1  one-cycle pulse: read data valid or write acknowledged.
- ld_rdata  out  32  loader read data; 0 on write ack.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
- err  out  1  one-cycle pulse on a misaligned or out-of-range request.

Behaviour:
- Reset: state IDLE; all outputs 0; counter 0; owner FETCH; dropped flag 0. Asserting rst mid-access abandons the access with no rvalid. A late mem_rdata is ignored.
- States:
  - IDLE: if any request is pending, pick an owner, pulse that requester's gnt and mem_en, latch owner/we, load cnt = MEM_LAT, go to WAIT.
  - WAIT: cnt decrements each cycle. On the cycle cnt==1, capture mem_rdata to the owner's rdata, pulse the owner's rvalid, go to IDLE.
  - Only one access is outstanding at a time. Back-to-back throughput is one access per MEM_LAT+1 cycles.
- Arbitration (default): fixed loader priority. When ld_req and fetch_req are both high, the loader wins and the fetch waits.
- Flush:
  - fetch_flush during WAIT with owner FETCH sets dropped. The memory access completes, but fetch_rvalid is suppressed.
  - fetch_flush on the same cycle the response would be issued also suppresses it.
  - fetch_flush in IDLE blocks a fetch grant that cycle.
  - fetch_flush has no effect on loader accesses.
- Alignment/range:
  - A request with addr[1:0] != 0 is served at the aligned word, and err pulses with gnt.
  - An address >= DEPTH_BYTES is granted without mem_en. err pulses with gnt. After MEM_LAT cycles, rvalid pulses with rdata = 0; a write is discarded.
- Writes: mem_we=1 with mem_en. ld_rvalid pulses after MEM_LAT cycles with ld_rdata = 0.
- rdata holds its last value between rvalid pulses.

Optional Feature:
- Macro: IMEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the requester that did not own the previous granted access wins. The last owner resets to FETCH, so the loader wins the first tie after reset.
- Undefined: fixed loader priority; the fetch port can starve while ld_req stays high.

Decomposition:
- Package imem_arb_pkg holds:
  - owner_t enum {OWN_FETCH, OWN_LD};
  - state_t enum {S_IDLE, S_WAIT};
  - WORD_BYTES = 4 and the aligned-address helper function.
- Sub-module imem_arb_pick (combinational grant select, with round-robin state under the macro) is natural. The FSM, counter and response logic stay in the top.

Test Plan:
- MEM_LAT=2. fetch_req with addr 0x10 at cycle 0 → fetch_gnt and mem_en at cycle 0, mem_addr=0x10. Memory returns 0xE3A00014 → fetch_rvalid at cycle 2 with that data.
- ld_req (write 0x12345678 @0x20) and fetch_req @0x24 at the same cycle → loader granted first with mem_we=1; ld_rvalid with rdata 0. Fetch is granted the cycle after ld_rvalid. With IMEM_ARB_RR_EN, a second tie grants the fetch.
- Fetch @0x08 granted, fetch_flush one cycle later → no fetch_rvalid; next fetch @0x30 is granted in IDLE and returns normally.
- Fetch @0x06 → err pulse; mem_addr=0x04. Fetch @0xC0 (DEPTH_BYTES=192) → err pulse, no mem_en, fetch_rvalid with rdata 0.
- rst asserted in WAIT → next cycle all outputs 0, no rvalid, and a new request is granted immediately after rst drops.
- Continuous fetch_req with incrementing PC over 8 words → exactly 8 rvalid pulses, in order, spaced MEM_LAT+1 cycles apart.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package imem_arb_pkg;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_LD = 1'b1} owner_t;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam int WORD_BYTES = 4;
  // Wide enough for the 1..15 cycle memory latency.
  localparam int CNT_W      = 4;
  // Widest address the alignment helper handles.
  localparam int MAX_AW     = 64;

  // Clear the byte-offset bits so the memory always sees a word address.
  function automatic logic [MAX_AW-1:0] align_word(input logic [MAX_AW-1:0] addr);
    return addr & ~MAX_AW'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and memory signals of the instruction-memory arbiter.
// The slave modport is the arbiter; the master modport is its environment
// (IF stage, loader and the memory itself).
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_flush;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [31:0]       fetch_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              err;

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output err
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  err
  );
endinterface

// File: rtl/imem_port_arbiter_pick.sv
// Grant select between fetch and loader requests.
// IMEM_ARB_RR_EN: round-robin on ties (last owner starts as fetch);
// otherwise the loader always wins a tie.
module imem_arb_pick
  import imem_arb_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic grant_en_i,
  input  logic fetch_req_i,
  input  logic ld_req_i,
  output logic fetch_gnt_o,
  output logic ld_gnt_o
);

`ifdef IMEM_ARB_RR_EN
  owner_t last_q, last_d;

  // Remember who owned the most recently granted access.
  always_ff @(posedge clk) begin
    if (rst) last_q <= OWN_FETCH;
    else     last_q <= last_d;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    fetch_gnt_o = 1'b0;
    ld_gnt_o    = 1'b0;
    last_d      = last_q;
    if (grant_en_i) begin
      if (fetch_req_i && ld_req_i) begin
        if (last_q == OWN_FETCH) ld_gnt_o    = 1'b1;
        else                     fetch_gnt_o = 1'b1;
      end else begin
        fetch_gnt_o = fetch_req_i;
        ld_gnt_o    = ld_req_i;
      end
      if (ld_gnt_o)         last_d = OWN_LD;
      else if (fetch_gnt_o) last_d = OWN_FETCH;
    end
  end
`else
  // Fixed priority: the loader always beats the fetch port.
  always_comb begin
    ld_gnt_o    = grant_en_i && ld_req_i;
    fetch_gnt_o = grant_en_i && fetch_req_i && !ld_req_i;
  end
`endif

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one fixed-latency instruction memory between the IF-stage fetch
// port and the boot/debug loader. One access outstanding at a time.
// Optional IMEM_ARB_RR_EN selects round-robin tie breaking in imem_arb_pick.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int DEPTH_BYTES = 192,
  parameter int ADDR_W      = 32
) (
  input logic               clk,
  input logic               rst,
  imem_port_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner_q, owner_d;
  logic             we_q, we_d;
  logic             oor_q, oor_d;
  logic             dropped_q, dropped_d;
  logic [31:0]      fetch_rdata_q, fetch_rdata_d;
  logic [31:0]      ld_rdata_q, ld_rdata_d;

  logic              grant_en, fetch_req_ok;
  logic              fetch_gnt, ld_gnt, any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oor, sel_mis;
  logic [31:0]       resp_data;
  logic              mem_en, mem_we, err, fetch_rvalid, ld_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // A flushing IF stage must not be granted; only idle cycles can grant.
  assign grant_en     = (state_q == S_IDLE) && !rst;
  assign fetch_req_ok = bus.fetch_req && !bus.fetch_flush;

  imem_arb_pick u_pick (
`ifdef IMEM_ARB_RR_EN
    .clk         (clk),
    .rst         (rst),
`endif
    .grant_en_i  (grant_en),
    .fetch_req_i (fetch_req_ok),
    .ld_req_i    (bus.ld_req),
    .fetch_gnt_o (fetch_gnt),
    .ld_gnt_o    (ld_gnt)
  );

  assign any_gnt  = fetch_gnt || ld_gnt;
  assign sel_addr = ld_gnt ? bus.ld_addr : bus.fetch_addr;
  assign sel_oor  = sel_addr >= ADDR_W'(DEPTH_BYTES);
  assign sel_mis  = sel_addr[1:0] != 2'b00;

  // State, latency counter and per-access context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      owner_q       <= OWN_FETCH;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      dropped_q     <= 1'b0;
      fetch_rdata_q <= '0;
      ld_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      oor_q         <= oor_d;
      dropped_q     <= dropped_d;
      fetch_rdata_q <= fetch_rdata_d;
      ld_rdata_q    <= ld_rdata_d;
    end
  end

  // Next state, memory strobes and response pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    we_d          = we_q;
    oor_d         = oor_q;
    dropped_d     = dropped_q;
    fetch_rdata_d = fetch_rdata_q;
    ld_rdata_d    = ld_rdata_q;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    err           = 1'b0;
    fetch_rvalid  = 1'b0;
    ld_rvalid     = 1'b0;
    // Writes and out-of-range accesses answer with zero.
    resp_data     = (we_q || oor_q) ? 32'h0 : bus.mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (any_gnt) begin
          state_d   = S_WAIT;
          cnt_d     = CNT_W'(MEM_LAT);
          owner_d   = ld_gnt ? OWN_LD : OWN_FETCH;
          we_d      = ld_gnt && bus.ld_we;
          oor_d     = sel_oor;
          dropped_d = 1'b0;
          err       = sel_mis || sel_oor;
          // Out-of-range accesses never touch the memory.
          if (!sel_oor) begin
            mem_en   = 1'b1;
            mem_we   = ld_gnt && bus.ld_we;
            mem_addr = ADDR_W'(align_word(MAX_AW'(sel_addr)));
            if (ld_gnt && bus.ld_we) mem_wdata = bus.ld_wdata;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (owner_q == OWN_FETCH && bus.fetch_flush) dropped_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (!rst) begin
            if (owner_q == OWN_LD) begin
              ld_rvalid  = 1'b1;
              ld_rdata_d = resp_data;
            end else if (!dropped_q && !bus.fetch_flush) begin
              fetch_rvalid  = 1'b1;
              fetch_rdata_d = resp_data;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.fetch_gnt    = fetch_gnt;
  assign bus.ld_gnt       = ld_gnt;
  assign bus.fetch_rvalid = fetch_rvalid;
  assign bus.ld_rvalid    = ld_rvalid;
  assign bus.fetch_rdata  = rst ? 32'h0 : fetch_rdata_d;
  assign bus.ld_rdata     = rst ? 32'h0 : ld_rdata_d;
  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.err          = err;

endmodule
